audio_pwm_out: RTL and testbench

Downstream audio output stage: accepts mixed 16-bit samples from the memory-playback controller on a one-cycle strobe and buffers them in a small FIFO. It converts each sample to a fixed-frequency PWM duty cycle for the board's mono audio jack and drives the amplifier shutdown pin. Sticky flags flag rate mismatch between producer and PWM frame rate.

---
 rtl/audio_pwm_out.sv | 106 ++++++++++
 tb/tb_audio_pwm_out.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: sample FIFO feeding a fixed-frame PWM audio output with amp shutdown control.
// Optional AUDIO_PWM_VOLUME_EN adds a volume attenuation port applied to duty at pop time.
module audio_pwm_out #(
   parameter int PWM_BITS   = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int IN_SHIFT   = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [15:0]                   sample_in,
   input  logic                          sample_valid,
   input  logic                          enable,
   input  logic                          clear_flags,
`ifdef AUDIO_PWM_VOLUME_EN
   input  logic [2:0]                    volume,
`endif
   output logic                          pwm_out,
   output logic                          amp_sd,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overrun,
   output logic                          underrun
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] HALF = (AW+1)'(FIFO_DEPTH / 2);
   localparam logic [15:0] DMAX = 16'((1 << PWM_BITS) - 1);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t                state_q;
   logic [PWM_BITS-1:0]   cnt_q, duty_q, sat, duty_new;
   logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]           level_q, level_d;
   logic                  pwm_q, amp_q, ovr_q, ovr_d, und_q, und_d;
   logic                  frame_end, pop, push_req, push;
   logic [15:0]           shifted;
   logic [15:0]           mem_q [FIFO_DEPTH];

   always_comb begin
      frame_end = state_q == RUN && cnt_q == '1;
      pop       = enable && ((state_q == PRIME && level_q >= HALF) || (frame_end && level_q != '0));
      push_req  = enable && sample_valid && state_q != IDLE;
      // a full FIFO still accepts a push when the same cycle frees an entry
      push      = push_req && (level_q != FULL || pop);
      wr_d      = enable ? wr_q + AW'(push) : '0;
      rd_d      = enable ? rd_q + AW'(pop) : '0;
      level_d   = enable ? level_q + (AW+1)'(push) - (AW+1)'(pop) : '0;
      ovr_d     = (ovr_q && !clear_flags) || (push_req && level_q == FULL && !pop);
      und_d     = (und_q && !clear_flags) || (enable && frame_end && level_q == '0);
      shifted   = mem_q[rd_q] >> IN_SHIFT;
      sat       = shifted > DMAX ? '1 : shifted[PWM_BITS-1:0];
`ifdef AUDIO_PWM_VOLUME_EN
      duty_new  = sat >> volume;
`else
      duty_new  = sat;
`endif
   end

   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= sample_in;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         duty_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         pwm_q   <= 1'b0;
         amp_q   <= 1'b0;
         ovr_q   <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
         ovr_q   <= ovr_d;
         und_q   <= und_d;
         amp_q   <= enable;
         pwm_q   <= enable && state_q == RUN && cnt_q < duty_q;
         if (!enable) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else
            case (state_q)
               IDLE:  state_q <= PRIME;
               PRIME: if (pop) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
                  duty_q  <= duty_new;
               end
               RUN: begin
                  cnt_q <= cnt_q + 1'b1;
                  if (pop) duty_q <= duty_new;
               end
               default: state_q <= IDLE;
            endcase
      end

   assign pwm_out    = pwm_q;
   assign amp_sd     = amp_q;
   assign fifo_level = level_q;
   assign overrun    = ovr_q;
   assign underrun   = und_q;
endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: directed checks of FIFO priming, PWM frame duty, flags, disable and async reset.
module tb_audio_pwm_out;
   logic        clk = 1'b0, rst_n = 1'b1;
   logic [15:0] sample_in = '0;
   logic        sample_valid = 1'b0, enable = 1'b1, clear_flags = 1'b0;
   logic [2:0]  volume = '0;
   logic        pwm_out, amp_sd, overrun, underrun;
   logic [2:0]  fifo_level;
   int          total = 0, bad = 0, hi, max_lvl = 0;

   audio_pwm_out dut (
      .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
      .enable(enable), .clear_flags(clear_flags),
`ifdef AUDIO_PWM_VOLUME_EN
      .volume(volume),
`endif
      .pwm_out(pwm_out), .amp_sd(amp_sd), .fifo_level(fifo_level),
      .overrun(overrun), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
   endtask

   task automatic frame(output int n);
      n = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         if (pwm_out) n++;
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_pwm", pwm_out, 0);
      check("rst_amp", amp_sd, 0);
      check("rst_lvl", fifo_level, 0);
      check("rst_flags", {overrun, underrun}, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) step();
      check("prime_amp", amp_sd, 1);
      check("prime_pwm", pwm_out, 0);
      check("prime_lvl", fifo_level, 0);
      check("prime_flags", {overrun, underrun}, 0);

      sample_valid = 1'b1; sample_in = 16'd1020;
      step();
      check("push1_lvl", fifo_level, 1);
      sample_in = 16'd512;
      step();
      check("push2_lvl", fifo_level, 2);
      sample_valid = 1'b0;
      step();
      check("prime_pop_lvl", fifo_level, 1);
      check("prime_pop_pwm", pwm_out, 0);
      frame(hi);
      check("frame1_hi", hi, 255);
      check("frame1_und", underrun, 0);
      frame(hi);
      check("frame2_hi", hi, 128);
      check("frame2_und", underrun, 1);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         clear_flags = (i == 0 || i == 255);
         step();
         if (pwm_out) hi++;
         if (i == 0) check("und_cleared", underrun, 0);
      end
      clear_flags = 1'b0;
      check("frame3_repeat_hi", hi, 128);
      check("und_set_wins", underrun, 1);
      check("no_ovr_yet", overrun, 0);

      sample_valid = 1'b1; sample_in = 16'd300;
      step();
      sample_valid = 1'b0;
      check("run_push_lvl", fifo_level, 1);
      step();
      step();
      check("mid_frame_pwm", pwm_out, 1);
      enable = 1'b0;
      step();
      check("dis_pwm", pwm_out, 0);
      check("dis_amp", amp_sd, 0);
      check("dis_lvl", fifo_level, 0);
      sample_valid = 1'b1; sample_in = 16'd700;
      step();
      sample_valid = 1'b0;
      check("idle_push_ignored", fifo_level, 0);

      enable = 1'b1;
      step();
      check("reen_amp", amp_sd, 1);
      sample_valid = 1'b1; sample_in = 16'd400;
      step();
      sample_in = 16'd800;
      step();
      check("reen_lvl2", fifo_level, 2);
      sample_in = 16'd1200;
      step();
      check("reen_pop_lvl", fifo_level, 2);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         sample_valid = (i <= 2 || i == 255);
         sample_in = i == 0 ? 16'd40 : i == 1 ? 16'd80 : i == 2 ? 16'd99 : 16'd2000;
         clear_flags = (i == 3);
         step();
         if (pwm_out) hi++;
         if (i == 1) check("full_lvl", fifo_level, 4);
         if (i == 1) check("full_no_ovr", overrun, 0);
         if (i == 2) check("drop_lvl", fifo_level, 4);
         if (i == 2) check("drop_ovr", overrun, 1);
         if (i == 3) check("ovr_cleared", overrun, 0);
         if (i == 255) check("pushpop_full_lvl", fifo_level, 4);
         if (i == 255) check("pushpop_full_ovr", overrun, 0);
      end
      sample_valid = 1'b0; clear_flags = 1'b0;
      check("duty100_hi", hi, 100);
      frame(hi);
      check("duty200_hi", hi, 200);
      frame(hi);
      check("sat1200_hi", hi, 255);
      check("lvl_after_pops", fifo_level, 2);
      check("lvl_max", max_lvl, 4);
      step();
      step();
      check("pre_rst_pwm", pwm_out, 1);
      #3 rst_n = 1'b0;
      #1;
      check("arst_pwm", pwm_out, 0);
      check("arst_amp", amp_sd, 0);
      check("arst_lvl", fifo_level, 0);
      check("arst_flags", {overrun, underrun}, 0);

`ifdef AUDIO_PWM_VOLUME_EN
      @(posedge clk);
      #1 rst_n = 1'b1;
      volume = 3'd2;
      step();
      sample_valid = 1'b1; sample_in = 16'd1020;
      step();
      step();
      sample_valid = 1'b0;
      step();
      frame(hi);
      check("vol2_hi", hi, 63);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
